// File: rtl/ram_pkg.sv
// Shared constants for the BRAM-backed FIFO: RAM read latency, skid depth
// and the width of the occupancy counter.
package ram_pkg;

  // Cycles from issuing a read address to dout holding the word.
  localparam int BRAMSD_RD_LAT = 2;

  // Entries in the output skid buffer that absorbs RAM read latency.
  localparam int SKID_DEPTH = 3;

  // Occupancy counter width: RAM words (2**addr_bits) plus skid/in-flight.
  function automatic int count_width(input int addr_bits);
    return addr_bits + 2;
  endfunction

endpackage

// File: rtl/bramsd.sv
// Simple dual-port block RAM: one write port, one read port with a
// registered address and a registered output (two-cycle read latency).
// Memory contents are never cleared; aclr only clears the read pipeline.
module bramsd #(
  parameter int ADDR_ = 4,
  parameter int DATA_ = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             we,
  input  logic [ADDR_-1:0] waddr,
  input  logic [DATA_-1:0] din,
  input  logic             re,
  input  logic [ADDR_-1:0] raddr,
  output logic [DATA_-1:0] dout
);

  logic [DATA_-1:0] mem [2**ADDR_];
  logic [ADDR_-1:0] raddr_q;

  // Write port: store din at waddr when we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
  end

  // Read pipeline: capture address on re, then register the addressed word.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      raddr_q <= '0;
      dout    <= '0;
    end else begin
      if (re) begin
        raddr_q <= raddr;
      end
      dout <= mem[raddr_q];
    end
  end

endmodule

// File: rtl/bram_fifo.sv
// FIFO built on a two-cycle-latency block RAM with a small skid buffer at
// the output so that out_data is registered and the FIFO still streams one
// word per cycle. count covers RAM words, reads in flight and skid entries.
module bram_fifo
  import ram_pkg::*;
#(
  parameter int ADDR_ = 4,
  parameter int DATA_ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATA_-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA_-1:0] out_data,
  output logic [ADDR_+1:0] count
);

  localparam int DEPTH = 2**ADDR_;
  localparam int CW    = count_width(ADDR_);
  localparam logic [2:0] SKID_LIM = 3'(SKID_DEPTH);

  // Registered state
  logic [ADDR_-1:0]         wptr;
  logic [ADDR_-1:0]         rptr;
  logic [ADDR_:0]           ram_count;
  logic [BRAMSD_RD_LAT-1:0] rd_vld;      // bit 0: stage 1, top bit: dout valid
  logic [DATA_-1:0]         skid [SKID_DEPTH];
  logic [1:0]               skid_count;
  logic [CW-1:0]            count_r;

  // Combinational control
  logic             push;
  logic             pop;
  logic             rd_issue;
  logic             skid_load;
  logic [2:0]       reserved;
  logic [2:0]       credit;
  logic [ADDR_:0]   ram_count_nxt;
  logic [1:0]       skid_count_nxt;
  logic [1:0]       wr_idx;
  logic [DATA_-1:0] skid_shift [SKID_DEPTH];
  logic [DATA_-1:0] skid_nxt   [SKID_DEPTH];
  logic [CW-1:0]    count_nxt;
  logic [DATA_-1:0] ram_dout;

  assign out_valid = (skid_count != 2'd0);
  assign out_data  = skid[0];
  assign count     = count_r;

  // Handshakes and read scheduling. A skid slot is reserved for every read in
  // flight; the slot freed by a pop in this same cycle counts as available,
  // which keeps the pipeline streaming at one word per cycle.
  always_comb begin
    in_ready  = (ram_count < (ADDR_+1)'(DEPTH)) & ~rst & ~clr;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready & ~rst & ~clr;
    reserved  = {1'b0, skid_count} + {2'b00, rd_vld[0]} + {2'b00, rd_vld[1]};
    credit    = SKID_LIM + {2'b00, pop};
    if ((ram_count != '0) && (reserved < credit) && !rst && !clr) begin
      rd_issue = 1'b1;
    end else begin
      rd_issue = 1'b0;
    end
    skid_load     = rd_vld[BRAMSD_RD_LAT-1];
    ram_count_nxt = ram_count + {{ADDR_{1'b0}}, push} - {{ADDR_{1'b0}}, rd_issue};
  end

  // Skid buffer next state: shift out the head on pop, then drop the returning
  // RAM word into the first free slot behind the remaining entries.
  always_comb begin
    for (int i = 0; i < SKID_DEPTH - 1; i++) begin
      skid_shift[i] = pop ? skid[i+1] : skid[i];
    end
    skid_shift[SKID_DEPTH-1] = pop ? '0 : skid[SKID_DEPTH-1];
    wr_idx = skid_count - {1'b0, pop};
    for (int i = 0; i < SKID_DEPTH; i++) begin
      if (skid_load && (wr_idx == 2'(i))) begin
        skid_nxt[i] = ram_dout;
      end else begin
        skid_nxt[i] = skid_shift[i];
      end
    end
    skid_count_nxt = skid_count + {1'b0, skid_load} - {1'b0, pop};
    count_nxt = CW'(ram_count_nxt) + CW'(rd_issue) + CW'(rd_vld[0])
              + CW'(skid_count_nxt);
  end

  // State update; rst and clr both return everything to empty, and clearing
  // the in-flight valids discards any RAM data still returning.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      ram_count  <= '0;
      rd_vld     <= '0;
      skid_count <= '0;
      count_r    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid[i] <= '0;
      end
    end else if (clr) begin
      wptr       <= '0;
      rptr       <= '0;
      ram_count  <= '0;
      rd_vld     <= '0;
      skid_count <= '0;
      count_r    <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid[i] <= '0;
      end
    end else begin
      if (push) begin
        wptr <= wptr + ADDR_'(1);
      end
      if (rd_issue) begin
        rptr <= rptr + ADDR_'(1);
      end
      ram_count  <= ram_count_nxt;
      rd_vld     <= {rd_vld[BRAMSD_RD_LAT-2:0], rd_issue};
      skid_count <= skid_count_nxt;
      count_r    <= count_nxt;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid[i] <= skid_nxt[i];
      end
    end
  end

  bramsd #(
    .ADDR_(ADDR_),
    .DATA_(DATA_)
  ) u_ram (
    .clk  (clk),
    .aclr (1'b0),
    .we   (push),
    .waddr(wptr),
    .din  (in_data),
    .re   (rd_issue),
    .raddr(rptr),
    .dout (ram_dout)
  );

endmodule
